// File: rtl/data_sync_tx.sv
// rtl/data_sync_tx.sv - source-domain launcher for the multi-bit bus synchronizer
// Holds a word on unsync_bus, raises bus_enable, and runs a 4-phase req/ack handshake.
module data_sync_tx #(
  parameter int WIDTH            = 8,
  parameter int FLIP_FLOP_STAGES = 3,
  parameter int TIMEOUT          = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             ready,
  output logic [WIDTH-1:0] unsync_bus,
  output logic             bus_enable,
  input  logic             dest_ack,
  output logic             tx_done,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t                      state, state_nx;
  logic [FLIP_FLOP_STAGES-1:0] ack_chain;
  logic                        ack_sync;
  logic [15:0]                 cnt, cnt_nx;
  logic [WIDTH-1:0]            bus_nx;
  logic                        en_nx;
  logic                        done_nx;
  logic                        to_nx;

  // dest_ack is asynchronous; only the last stage of the chain is trusted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_chain <= '0;
    end else begin
      ack_chain <= {ack_chain[FLIP_FLOP_STAGES-2:0], dest_ack};
    end
  end

  assign ack_sync = ack_chain[FLIP_FLOP_STAGES-1];
  assign ready    = (state == IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      unsync_bus  <= '0;
      bus_enable  <= 1'b0;
      cnt         <= '0;
      tx_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      unsync_bus  <= bus_nx;
      bus_enable  <= en_nx;
      cnt         <= cnt_nx;
      tx_done     <= done_nx;
      timeout_err <= to_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bus_nx   = unsync_bus;
    en_nx    = bus_enable;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          bus_nx   = data_in;
          en_nx    = 1'b1;
          cnt_nx   = '0;
          state_nx = REQ;
        end
      end
      REQ: begin
        // ack takes priority over a timeout landing on the same cycle
        if (ack_sync) begin
          en_nx    = 1'b0;
          done_nx  = 1'b1;
          state_nx = RELEASE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          en_nx    = 1'b0;
          to_nx    = 1'b1;
          state_nx = RELEASE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      RELEASE: begin
        en_nx = 1'b0;
        if (!ack_sync) begin
          state_nx = IDLE;
        end
      end
      default: begin
        en_nx    = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_sync_tx.sv
// tb/tb_data_sync_tx.sv - scoreboard bench for data_sync_tx
// Stimulus pushes expected completions; a negedge monitor pops them on tx_done/timeout_err.
module tb_data_sync_tx;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int TO = 8;

  typedef struct packed {
    logic [W-1:0] word;
    logic         is_timeout;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         ready;
  logic [W-1:0] unsync_bus;
  logic         bus_enable;
  logic         dest_ack;
  logic         tx_done;
  logic         timeout_err;

  logic         auto_ack = 1'b0;
  logic         model_ack = 1'b0;
  logic         man_ack = 1'b0;
  int           hi_cnt = 0;
  int           lo_cnt = 0;
  int           cyc = 0;
  int           ack_rise_cyc = 0;
  logic [W-1:0] cur_word = '0;
  logic         prev_pulse = 1'b0;
  exp_t         sb[$];

  int checks = 0;
  int failures = 0;

  assign dest_ack = auto_ack ? model_ack : man_ack;

  data_sync_tx #(.WIDTH(W), .FLIP_FLOP_STAGES(S), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid),
    .ready(ready), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .dest_ack(dest_ack), .tx_done(tx_done), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Destination model: ack rises 2 cycles after bus_enable, falls 2 cycles after it drops
  initial forever begin
    @(posedge CLK); #1;
    if (auto_ack) begin
      if (bus_enable) begin
        lo_cnt = 0;
        if (hi_cnt < 1) hi_cnt++;
        else if (!model_ack) begin
          model_ack = 1'b1;
          ack_rise_cyc = cyc;
        end
      end else begin
        hi_cnt = 0;
        if (model_ack) begin
          if (lo_cnt < 1) lo_cnt++;
          else model_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every completion pulse
  always @(negedge CLK) begin
    if (RST) begin
      if (tx_done || timeout_err) begin
        chk("pulse_exclusive", {31'd0, tx_done & timeout_err}, 32'd0);
        chk("pulse_not_back_to_back", {31'd0, prev_pulse}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_word", unsync_bus, e.word);
          chk("done_is_timeout", {31'd0, timeout_err}, {31'd0, e.is_timeout});
          chk("done_is_ack", {31'd0, tx_done}, {31'd0, ~e.is_timeout});
          if (tx_done && auto_ack)
            chk("tx_done_latency", cyc - ack_rise_cyc, S + 1);
        end
      end
      if (!ready) chk("bus_stable", unsync_bus, cur_word);
      prev_pulse <= tx_done | timeout_err;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 300; i++) begin
      if (ready) return;
      @(posedge CLK); #1;
    end
    chk(name, 32'd0, 32'd1);
  endtask

  // Leaves data_valid high; returns #1 after the accept edge
  task automatic send(input logic [W-1:0] w, input logic is_to, input logic push);
    data_in = w;
    data_valid = 1'b1;
    wait_ready("send_wait_ready");
    @(posedge CLK); #1;
    cur_word = w;
    if (push) sb.push_back('{word: w, is_timeout: is_to});
    chk("accept_bus", unsync_bus, w);
    chk("accept_enable", {31'd0, bus_enable}, 32'd1);
    chk("accept_ready_low", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_enable", {31'd0, bus_enable}, 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_bus", unsync_bus, 32'h00);
    chk("post_rst_enable", {31'd0, bus_enable}, 32'd0);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    chk("post_rst_pulses", {30'd0, tx_done, timeout_err}, 32'd0);

    // Normal transfer, with busy rejection during REQ
    auto_ack = 1'b1;
    send(8'hAA, 1'b0, 1'b1);
    data_in = 8'hFF;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    chk("busy_bus_held", unsync_bus, 32'hAA);
    data_valid = 1'b0;
    wait_ready("normal_idle");
    chk("normal_bus_kept", unsync_bus, 32'hAA);
    chk("normal_sb_drained", sb.size(), 32'd0);
    repeat (4) begin
      @(posedge CLK); #1;
    end
    chk("no_second_tx_enable", {31'd0, bus_enable}, 32'd0);
    chk("idle_bus_kept", unsync_bus, 32'hAA);
    send(8'hAE, 1'b0, 1'b1);
    data_valid = 1'b0;
    wait_ready("second_idle");
    chk("second_bus", unsync_bus, 32'hAE);

    // Back-to-back with data_valid held high
    for (int i = 1; i <= 4; i++) send(W'(i), 1'b0, 1'b1);
    data_valid = 1'b0;
    wait_ready("b2b_idle");
    repeat (8) begin
      @(posedge CLK); #1;
    end
    chk("b2b_sb_drained", sb.size(), 32'd0);
    chk("b2b_last_bus", unsync_bus, 32'h04);

    // Timeout with ack tied low
    auto_ack = 1'b0;
    man_ack = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
    end
    send(8'h55, 1'b1, 1'b1);
    data_valid = 1'b0;
    begin
      int hi = 0;
      for (int i = 0; i < 100 && bus_enable; i++) begin
        hi++;
        @(posedge CLK); #1;
      end
      chk("timeout_enable_cycles", hi, TO);
    end
    chk("timeout_release_ready", {31'd0, ready}, 32'd0);
    @(posedge CLK); #1;
    chk("timeout_ready_back", {31'd0, ready}, 32'd1);

    // Ack/timeout collision: ack_sync first high on the 8th REQ cycle
    send(8'h3C, 1'b0, 1'b1);
    data_valid = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    man_ack = 1'b1;
    for (int i = 0; i < 50 && bus_enable; i++) begin
      @(posedge CLK); #1;
    end
    man_ack = 1'b0;
    wait_ready("collision_idle");
    chk("collision_sb_drained", sb.size(), 32'd0);

    // Stuck-high ack in IDLE completes the next REQ immediately
    man_ack = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
    end
    chk("idle_ack_ignored", {31'd0, ready}, 32'd1);
    send(8'h5A, 1'b0, 1'b1);
    data_valid = 1'b0;
    @(posedge CLK); #1;
    chk("stuck_ack_enable_drop", {31'd0, bus_enable}, 32'd0);
    man_ack = 1'b0;
    wait_ready("stuck_idle");

    // Mid-REQ asynchronous reset
    send(8'h77, 1'b0, 1'b0);
    data_valid = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    #2 RST = 1'b0;
    #1;
    chk("midrst_enable", {31'd0, bus_enable}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_bus", unsync_bus, 32'h00);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    chk("midrst_stays_idle", {30'd0, ready, bus_enable}, 32'd2);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
